// File: rtl/auto_transition.sv
// Auto-take controller: ramps a virtual T-bar position toward the A end (0) or the B end (all-ones).
// Optional freeze input is compiled in only when AUTO_TRANS_PAUSE_EN is defined.
module auto_transition #(
    parameter int MIX_W = 10,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_a,
    input  logic             trig_b,
    input  logic [MIX_W-1:0] tbar,
    input  logic [DIV_W-1:0] div,
    input  logic [MIX_W-1:0] step,
    input  logic             pause,
    output logic [MIX_W-1:0] mix_val,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             dir,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SYNC = 2'b00,
        IDLE = 2'b01,
        RUN  = 2'b11,
        DONE = 2'b10
    } state_t;

    localparam logic [MIX_W-1:0] MIX_MAX  = {MIX_W{1'b1}};
    localparam logic [MIX_W-1:0] MIX_ZERO = {MIX_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [MIX_W-1:0] pos_r;
    logic [MIX_W-1:0] pos_nxt_s;
    logic [MIX_W-1:0] tbar_q_r;
    logic [DIV_W-1:0] presc_r;
    logic [DIV_W-1:0] presc_nxt_s;
    logic             dir_r;
    logic             dir_nxt_s;
    logic             abort_nxt_s;
    logic             valid_trig_s;
    logic             tbar_chg_s;
    logic             freeze_s;
    logic [MIX_W-1:0] target_s;
    logic [MIX_W-1:0] stepped_s;

    // Move p by max(s,1) toward the chosen end, saturating at that end.
    function automatic logic [MIX_W-1:0] advance(
        input logic [MIX_W-1:0] p,
        input logic [MIX_W-1:0] s,
        input logic             to_b
    );
        logic [MIX_W:0] s_eff;
        logic [MIX_W:0] sum;
        s_eff = (s == MIX_ZERO) ? {{MIX_W{1'b0}}, 1'b1} : {1'b0, s};
        if (to_b) begin
            sum = {1'b0, p} + s_eff;
            if (sum >= {1'b0, MIX_MAX}) begin
                advance = MIX_MAX;
            end else begin
                advance = sum[MIX_W-1:0];
            end
        end else begin
            if ({1'b0, p} <= s_eff) begin
                advance = MIX_ZERO;
            end else begin
                sum     = {1'b0, p} - s_eff;
                advance = sum[MIX_W-1:0];
            end
        end
    endfunction

    assign valid_trig_s = trig_a ^ trig_b;
    assign tbar_chg_s   = (tbar != tbar_q_r);
    assign target_s     = dir_r ? MIX_MAX : MIX_ZERO;
    assign stepped_s    = advance(pos_r, step, dir_r);

`ifdef AUTO_TRANS_PAUSE_EN
    assign freeze_s = pause;
`else
    logic unused_pause_s;
    assign unused_pause_s = pause;
    assign freeze_s       = 1'b0;
`endif

    // Next-state, position, direction and prescaler decisions.
    always_comb begin
        state_nxt_s = state_r;
        pos_nxt_s   = pos_r;
        dir_nxt_s   = dir_r;
        presc_nxt_s = presc_r;
        abort_nxt_s = 1'b0;
        case (state_r)
            SYNC: begin
                pos_nxt_s   = tbar;
                state_nxt_s = IDLE;
            end
            IDLE: begin
                if (valid_trig_s) begin
                    dir_nxt_s   = trig_b;
                    presc_nxt_s = DIV_ZERO;
                    if (pos_r == (trig_b ? MIX_MAX : MIX_ZERO)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (tbar_chg_s) begin
                    pos_nxt_s = tbar;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (tbar_chg_s && !valid_trig_s) begin
                    pos_nxt_s   = tbar;
                    abort_nxt_s = 1'b1;
                    state_nxt_s = IDLE;
                end else if (valid_trig_s && (trig_b != dir_r)) begin
                    // Reversal keeps the prescaler phase; the new heading applies at the next tick.
                    dir_nxt_s = trig_b;
                    if (pos_r == (trig_b ? MIX_MAX : MIX_ZERO)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (freeze_s) begin
                    state_nxt_s = RUN;
                end else if (presc_r == div) begin
                    presc_nxt_s = DIV_ZERO;
                    pos_nxt_s   = stepped_s;
                    if (stepped_s == target_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    presc_nxt_s = presc_r + DIV_ONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = SYNC;
            end
        endcase
    end

    // State, position and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= SYNC;
            pos_r    <= MIX_ZERO;
            tbar_q_r <= MIX_ZERO;
            presc_r  <= DIV_ZERO;
            dir_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pos_r    <= pos_nxt_s;
            tbar_q_r <= tbar;
            presc_r  <= presc_nxt_s;
            dir_r    <= dir_nxt_s;
            busy     <= (state_nxt_s == RUN);
            done     <= (state_nxt_s == DONE);
            aborted  <= abort_nxt_s;
        end
    end

    assign mix_val = pos_r;
    assign dir     = dir_r;
    assign state   = state_r;

endmodule
